rect_drawer: RTL and testbench
==============================

# rect_drawer

Parametrised rectangle rasteriser for the VGA drawing path. It accepts a rectangle (origin, size, colour, mode) on a one-cycle `go` and emits one pixel per accepted cycle on a plot/ready interface toward the VGA adapter. Control FSM and coordinate counters are in one block. Versus the earlier fixed-size box drawer it adds parametrised coordinate widths, outline mode, backpressure, zero-size handling and optional screen clipping.

## Interface
- `XW`, 8, x coordinate/width bits
- `YW`, 7, y coordinate/height bits
- `CW`, 3, colour bits
- `SCREEN_W`, 160, visible columns (clip only)
- `SCREEN_H`, 120, visible rows (clip only)
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-low
- `go`  in  1  start request; sampled only in IDLE
- `x0`  in  XW  left column
- `y0`  in  YW  top row
- `w`  in  XW  width in pixels; 0 means empty
- `h`  in  YW  height in pixels; 0 means empty
- `colour_in`  in  CW  fill colour
- `outline`  in  1  1 = border pixels only; 0 = solid fill
- `pix_ready`  in  1  adapter accepts the current pixel
- `x`  out  XW  pixel column
- `y`  out  YW  pixel row
- `colour`  out  CW  pixel colour
- `plot`  out  1  pixel valid
- `busy`  out  1  high in DRAW and DONE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: if `go`=1, latch x0, y0, w, h, colour_in and outline. Set cx=0 and cy=0. Next state is DRAW, or DONE if w==0 or h==0.
- DRAW: `plot`=1 and x=x0+cx, y=y0+cy. A pixel is accepted when plot and pix_ready are both 1.
- Step on acceptance: if cx==w-1, set cx=0 and cy=cy+1; otherwise cx=cx+1. The last pixel (cx==w-1, cy==h-1) moves to DONE.
- Outline mode on an interior row (0<cy<h-1): after cx=0, cx jumps to w-1. Rows with w==1 emit one pixel. h==1 emits a single row.
- DONE: `done`=1 for one cycle, then IDLE.
- `go` is ignored while busy. Latched operands hold for the whole operation, so input changes have no effect until the next start.
- While plot=1 and pix_ready=0, x, y, colour and plot stay stable.
- Arithmetic: cx and cy are XW and YW bits wide. Without clip, x0+cx and y0+cy wrap modulo 2^XW and 2^YW.
- Reset mid-operation: next state is IDLE and the current pixel is discarded.
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0.

## Timing
- `go` sampled at edge N gives the first pixel on the outputs in cycle N+1.
- With pix_ready held at 1: a fill takes w·h DRAW cycles, and done is high in cycle N+1+w·h. An outline takes 2w+2(h−2) pixels when h≥2 and w≥2.
- Zero-size rectangle: done is high in cycle N+1, with no plot.
- Earliest restart: `go` in the cycle after done.
- Outputs are registered; no combinational path from pix_ready to outputs.

## Configuration
- `RECT_CLIP_EN` defined: x0+cx and y0+cy are computed in XW+1 and YW+1 bits. Pixels with column ≥ SCREEN_W or row ≥ SCREEN_H are presented with plot=0 for one cycle each and skipped without waiting on pix_ready. Cycle count is unchanged when pix_ready is held at 1.
- Undefined: no clipping, and coordinates wrap as above.

## Structure
- Package `draw_pkg` holds the state enum (IDLE/DRAW/DONE) and the default screen constants 160×120 and colour width 3, shared with other draw blocks.
- One sub-module, `rect_scan_counter`: the cx/cy stepper with the outline skip and last-pixel flag. The FSM and output registers live in the top module.

## Test plan
- Fill, x0=10, y0=5, w=3, h=2, pix_ready=1: six pixels (10,5), (11,5), (12,5), (10,6), (11,6), (12,6); done in cycle N+7.
- Outline, w=4, h=3: ten pixels; row 1 emits only x0 and x0+3.
- w=0, h=5: no plot; done in cycle N+1. Then w=1, h=1: exactly one pixel.
- pix_ready toggled 1,0,0,1 during a fill: outputs hold across the stalls, no pixel is lost or duplicated, and done is delayed by 2 cycles.
- Reset low during the 3rd pixel of a fill: next cycle plot=0, busy=0, done=0. A new `go` restarts from (x0,y0).
- With RECT_CLIP_EN, x0=158, w=4, y0=0, h=1: only columns 158 and 159 plotted, and done in cycle N+5. Without the macro: columns 158, 159, 160, 161 are plotted, none wrapping with XW=8.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the drawing blocks: FSM state encoding and default
// screen geometry / colour depth.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_t;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int CW_DEF       = 3;

endpackage

// File: rtl/rect_scan_counter.sv
// Column/row stepper for the rectangle scan. It presents the position that
// follows the current one, including the outline jump across interior rows.
module rect_scan_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic          outline,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny,
  output logic          last
);

  logic [XW-1:0] cx_reg;
  logic [YW-1:0] cy_reg;
  logic [XW-1:0] w_m1;
  logic [YW-1:0] h_m1;
  logic          row_end;
  logic          interior;

  assign w_m1     = w - XW'(1);
  assign h_m1     = h - YW'(1);
  assign row_end  = (cx_reg == w_m1);
  assign interior = outline && (cy_reg != '0) && (cy_reg != h_m1);
  assign last     = row_end && (cy_reg == h_m1);

  always_comb begin
    nx = cx_reg + XW'(1);
    ny = cy_reg;
    if (row_end) begin
      nx = '0;
      ny = cy_reg + YW'(1);
    end else if (interior && (cx_reg == '0)) begin
      // Border-only rows need just the left and right pixels.
      nx = w_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || load) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (step) begin
      cx_reg <= nx;
      cy_reg <= ny;
    end
  end

endmodule

// File: rtl/rect_drawer.sv
// Rectangle rasteriser: one pixel per accepted cycle on a plot/ready port.
// Define RECT_CLIP_EN to suppress pixels outside SCREEN_W x SCREEN_H.
module rect_drawer
  import draw_pkg::*;
#(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = CW_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic [CW-1:0] colour_in,
  input  logic          outline,
  input  logic          pix_ready,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  draw_state_t   state_reg, state_next;
  logic [XW-1:0] x0_reg, w_reg;
  logic [YW-1:0] y0_reg, h_reg;
  logic [CW-1:0] colour_l_reg;
  logic          outline_reg;

  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [CW-1:0] colour_reg, colour_next;
  logic          plot_reg, plot_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic          start, empty, advance, last;
  logic [XW-1:0] nx, base_x, off_x, px;
  logic [YW-1:0] ny, base_y, off_y, py;
  logic          vis;

  assign start = (state_reg == IDLE) && go;
  assign empty = (w == '0) || (h == '0);
  // A clipped pixel (plot low while drawing) is skipped without waiting.
  assign advance = (state_reg == DRAW) && (pix_ready || !plot_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      x0_reg       <= '0;
      y0_reg       <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      colour_l_reg <= '0;
      outline_reg  <= 1'b0;
    end else if (start) begin
      x0_reg       <= x0;
      y0_reg       <= y0;
      w_reg        <= w;
      h_reg        <= h;
      colour_l_reg <= colour_in;
      outline_reg  <= outline;
    end
  end

  rect_scan_counter #(.XW(XW), .YW(YW)) u_scan (
    .clk     (clk),
    .reset   (reset),
    .load    (start),
    .step    (advance),
    .w       (w_reg),
    .h       (h_reg),
    .outline (outline_reg),
    .nx      (nx),
    .ny      (ny),
    .last    (last)
  );

  // The first pixel comes straight from the inputs; later ones from the stepper.
  assign base_x = start ? x0 : x0_reg;
  assign base_y = start ? y0 : y0_reg;
  assign off_x  = start ? '0 : nx;
  assign off_y  = start ? '0 : ny;

`ifdef RECT_CLIP_EN
  localparam logic [XW:0] SCREEN_W_C = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] SCREEN_H_C = (YW+1)'(SCREEN_H);
  logic [XW:0] px_full;
  logic [YW:0] py_full;
  assign px_full = {1'b0, base_x} + {1'b0, off_x};
  assign py_full = {1'b0, base_y} + {1'b0, off_y};
  assign px      = px_full[XW-1:0];
  assign py      = py_full[YW-1:0];
  assign vis     = (px_full < SCREEN_W_C) && (py_full < SCREEN_H_C);
`else
  assign px  = base_x + off_x;
  assign py  = base_y + off_y;
  assign vis = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
      plot_reg   <= plot_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go) state_next = empty ? DONE : DRAW;
      DRAW:    if (advance && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    x_next      = x_reg;
    y_next      = y_reg;
    colour_next = colour_reg;
    plot_next   = 1'b0;
    busy_next   = (state_next != IDLE);
    done_next   = (state_next == DONE);
    case (state_reg)
      IDLE: begin
        if (go && !empty) begin
          x_next      = px;
          y_next      = py;
          colour_next = colour_in;
          plot_next   = vis;
        end
      end
      DRAW: begin
        if (!advance) begin
          plot_next = plot_reg;
        end else if (!last) begin
          x_next      = px;
          y_next      = py;
          colour_next = colour_l_reg;
          plot_next   = vis;
        end
      end
      default: begin
      end
    endcase
  end

  assign x      = x_reg;
  assign y      = y_reg;
  assign colour = colour_reg;
  assign plot   = plot_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_rect_drawer.sv
// Directed bench for rect_drawer: table of rectangles plus reset/stall cases.
// Honours RECT_CLIP_EN the same way as the design.
module tb_rect_drawer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic [7:0] x0 = '0, w = '0;
  logic [6:0] y0 = '0, h = '0;
  logic [2:0] colour_in = '0;
  logic       outline = 1'b0;
  logic       pix_ready = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  rect_drawer dut (
    .clk(clk), .reset(reset), .go(go), .x0(x0), .y0(y0), .w(w), .h(h),
    .colour_in(colour_in), .outline(outline), .pix_ready(pix_ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, w, h, col;
    bit outl;
    int stall_mask;
    int exp_pix;
    int exp_done;
  } vec_t;

  vec_t vecs[13];
  int   n_checks = 0;
  int   n_pass = 0;
  int   gx[$], gy[$], gc[$];
  int   mx[$], my[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input int a, b, c, d, e, input bit o,
                              input int m, p, q);
    vec_t v;
    v.x0 = a; v.y0 = b; v.w = c; v.h = d; v.col = e; v.outl = o;
    v.stall_mask = m; v.exp_pix = p; v.exp_done = q;
    return v;
  endfunction

  // Reference scan: which pixels should appear, in order.
  task automatic build_model(input vec_t v);
    mx.delete(); my.delete();
    for (int cy = 0; cy < v.h; cy++)
      for (int cx = 0; cx < v.w; cx++) begin
        int px, py;
        if (v.outl && !(cy == 0 || cy == v.h - 1 || cx == 0 || cx == v.w - 1))
          continue;
        px = v.x0 + cx;
        py = v.y0 + cy;
`ifdef RECT_CLIP_EN
        if (px >= 160 || py >= 120) continue;
`endif
        mx.push_back(px % 256);
        my.push_back(py % 128);
      end
  endtask

  task automatic run_rect(input vec_t v, input string tag, output int done_k);
    bit stall_prev;
    int sx, sy, sc;
    gx.delete(); gy.delete(); gc.delete();
    done_k = -1;
    stall_prev = 1'b0;
    sx = 0; sy = 0; sc = 0;
    @(posedge clk); #1;
    go = 1'b1; x0 = 8'(v.x0); y0 = 7'(v.y0); w = 8'(v.w); h = 7'(v.h);
    colour_in = 3'(v.col); outline = v.outl; pix_ready = 1'b1;
    @(negedge clk);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_done"}, done, 0);
    @(posedge clk); #1;
    for (int k = 1; k <= 200; k++) begin
      // Busy-time go with junk operands must be ignored.
      go = 1'b1;
      x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom);
      h = 7'($urandom); colour_in = 3'($urandom); outline = 1'($urandom);
      pix_ready = (k <= 32) ? !v.stall_mask[k-1] : 1'b1;
      @(negedge clk);
      if (stall_prev) begin
        chk({tag, " hold_x"}, x, sx);
        chk({tag, " hold_y"}, y, sy);
        chk({tag, " hold_colour"}, colour, sc);
        chk({tag, " hold_plot"}, plot, 1);
      end
      if (done) begin
        done_k = k;
        go = 1'b0;
        chk({tag, " busy_at_done"}, busy, 1);
        chk({tag, " plot_at_done"}, plot, 0);
        break;
      end
      chk({tag, " busy"}, busy, 1);
      if (plot && pix_ready) begin
        gx.push_back(x); gy.push_back(y); gc.push_back(colour);
      end
      stall_prev = plot && !pix_ready;
      sx = x; sy = y; sc = colour;
      @(posedge clk); #1;
    end
    go = 1'b0;
    pix_ready = 1'b1;
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    int dk, n;
    build_model(v);
    run_rect(v, tag, dk);
    chk({tag, " done_cycle"}, dk, v.exp_done);
    chk({tag, " pixel_count"}, gx.size(), v.exp_pix);
    n = (gx.size() < mx.size()) ? gx.size() : mx.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s px%0d_x", tag, i), gx[i], mx[i]);
      chk($sformatf("%s px%0d_y", tag, i), gy[i], my[i]);
      chk($sformatf("%s px%0d_colour", tag, i), gc[i], v.col);
    end
    $display("%s: x0=%0d y0=%0d w=%0d h=%0d outline=%0d pixels=%0d done_cycle=%0d",
             tag, v.x0, v.y0, v.w, v.h, v.outl, gx.size(), dk);
  endtask

  initial begin
    //           x0   y0  w  h col out mask     pix done
    vecs[0]  = mk(10,   5, 3, 2, 5, 0, 0,        6,  7);
    vecs[1]  = mk(20,  30, 4, 3, 3, 1, 0,       10, 11);
    vecs[2]  = mk( 0,   0, 0, 5, 1, 0, 0,        0,  1);
    vecs[3]  = mk( 7,   7, 1, 1, 6, 0, 0,        1,  2);
    vecs[4]  = mk(10,   5, 3, 2, 2, 0, 32'h6,    6,  9);
    vecs[5]  = mk(40,  50, 1, 4, 4, 1, 0,        4,  5);
    vecs[6]  = mk(60,  10, 5, 1, 7, 1, 0,        5,  6);
    vecs[7]  = mk( 3,   3, 3, 0, 1, 0, 0,        0,  1);
    vecs[8]  = mk(90, 100, 2, 2, 5, 1, 0,        4,  5);
    vecs[9]  = mk(30,  20, 5, 4, 1, 1, 32'h8,   14, 16);
`ifdef RECT_CLIP_EN
    vecs[10] = mk(158,  0, 4, 1, 3, 0, 0,        2,  5);
    vecs[11] = mk(250,  2, 8, 1, 3, 0, 0,        0,  9);
    vecs[12] = mk( 0, 125, 1, 4, 6, 0, 0,        0,  5);
`else
    vecs[10] = mk(158,  0, 4, 1, 3, 0, 0,        4,  5);
    vecs[11] = mk(250,  2, 8, 1, 3, 0, 0,        8,  9);
    vecs[12] = mk( 0, 125, 1, 4, 6, 0, 0,        4,  5);
`endif

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset x", x, 0);
    chk("reset y", y, 0);
    chk("reset colour", colour, 0);
    chk("reset plot", plot, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    $display("reset: x=%0d y=%0d plot=%0d busy=%0d done=%0d", x, y, plot, busy, done);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 13; i++)
      run_and_check(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while the third pixel of a fill is presented.
    @(posedge clk); #1;
    go = 1'b1; x0 = 8'd10; y0 = 7'd5; w = 8'd3; h = 7'd2;
    colour_in = 3'd5; outline = 1'b0; pix_ready = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset third_x", x, 12);
    chk("midreset third_plot", plot, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreset plot", plot, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    $display("midreset: plot=%0d busy=%0d done=%0d", plot, busy, done);
    @(posedge clk); #1;
    reset = 1'b1;
    run_and_check(vecs[0], "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
